router_ctrl: RTL and testbench

//  Ingress controller for the 1x3 router. Parses byte packets from the source, steers each

---
 rtl/router_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_router_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_ctrl.sv
// router_ctrl: ingress controller for the 1x3 router.
// Parses byte packets (header, len payload bytes, parity byte) and steers each
// packet to one of three FIFOs through a single holding register. It checks
// the packet parity and runs a per-channel read timeout that flushes stalled
// FIFOs.
//
// Handshake: a source byte is transferred on a rising edge where
// pkt_valid && !busy. While busy is high the source keeps data_in and
// pkt_valid stable. busy is combinational from state, hold register and FIFO
// status. It never depends on pkt_valid, so there is no combinational loop
// through the source.
//
// Header layout: [1:0] = destination (3 = invalid, packet dropped),
// [7:2] = payload length. The field positions are fixed, so DATA_WIDTH must
// stay 8.
module router_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 30
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [2:0]            fifo_full,
    input  logic [2:0]            fifo_empty,
    input  logic [2:0]            read_enb,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            write_enb_n,
    output logic [2:0]            vld_out,
    output logic [2:0]            soft_reset,
    output logic                  parity_done,
    output logic                  err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_EMPTY = 3'd1,
        S_PAYLOAD    = 3'd2,
        S_PARITY     = 3'd3,
        S_CHECK      = 3'd4,
        S_DROP       = 3'd5
    } state_t;

    // Packet parser state and datapath registers.
    state_t                  state_q, state_d;
    logic                    hold_vld_q, hold_vld_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [1:0]              dest_q, dest_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   par_q, par_d;
    logic [DATA_WIDTH-1:0]   rx_par_q, rx_par_d;
    logic [6:0]              drop_cnt_q, drop_cnt_d;
    logic                    err_q, err_d;
    logic                    parity_done_q, parity_done_d;

    // Per-channel timeout machinery.
    logic [2:0]              soft_reset_q, soft_reset_d;
    logic [2:0][TW-1:0]      tcnt_q, tcnt_d;

    // Combinational helpers.
    logic                    accept;
    logic                    full_dest;
    logic                    empty_dest;
    logic                    srst_dest;
    logic                    wr_go;
    logic [2:0]              wr_vec;
    logic                    load_hold;
    logic                    clear_hold;

    // Select one channel status bit by destination. Destination 3 has no
    // FIFO, so it reads as 0.
    function automatic logic pick(input logic [2:0] v, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign full_dest  = pick(fifo_full, dest_q);
    assign empty_dest = pick(fifo_empty, dest_q);
    assign srst_dest  = pick(soft_reset_q, dest_q);

    // The held byte goes out whenever the destination has room. The header
    // additionally waits until the destination FIFO has fully drained.
    assign wr_go = hold_vld_q && !full_dest &&
                   ((state_q != S_WAIT_EMPTY) || empty_dest);

    assign accept = pkt_valid && !busy;

    // Backpressure toward the source, derived from state and hold occupancy.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_WAIT_EMPTY: busy = 1'b1;
            S_CHECK:      busy = 1'b1;
            S_PAYLOAD:    busy = hold_vld_q && full_dest;
            S_PARITY:     busy = hold_vld_q && full_dest;
            default:      busy = 1'b0;
        endcase
    end

    // One-hot write strobe toward the destination FIFO.
    always_comb begin
        wr_vec = 3'b000;
        if (wr_go) begin
            case (dest_q)
                2'd0:    wr_vec = 3'b001;
                2'd1:    wr_vec = 3'b010;
                2'd2:    wr_vec = 3'b100;
                default: wr_vec = 3'b000;
            endcase
        end
    end

    // Parser next state: header decode, payload tracking, parity check, drop.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        dest_d        = dest_q;
        cnt_d         = cnt_q;
        par_d         = par_q;
        rx_par_d      = rx_par_q;
        drop_cnt_d    = drop_cnt_q;
        err_d         = err_q;
        parity_done_d = 1'b0;
        load_hold     = 1'b0;
        clear_hold    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dest_d = data_in[1:0];
                    cnt_d  = data_in[7:2];
                    par_d  = data_in;
                    err_d  = 1'b0;
                    if (data_in[1:0] == 2'd3) begin
                        // Invalid destination: swallow header-length bytes plus parity.
                        drop_cnt_d = {1'b0, data_in[7:2]} + 7'd1;
                        state_d    = S_DROP;
                    end else begin
                        data_d    = data_in;
                        load_hold = 1'b1;
                        state_d   = S_WAIT_EMPTY;
                    end
                end
            end

            S_WAIT_EMPTY: begin
                // A soft reset here is ignored; the header is still pending.
                if (wr_go) begin
                    state_d = (cnt_q != 6'd0) ? S_PAYLOAD : S_PARITY;
                end
            end

            S_PAYLOAD: begin
                if (srst_dest) begin
                    // Destination flushed: discard the rest of the packet.
                    // A byte accepted this very edge is one of the remaining
                    // ones, so it is counted as already dropped.
                    clear_hold = 1'b1;
                    state_d    = S_DROP;
                    drop_cnt_d = accept ? {1'b0, cnt_q} : ({1'b0, cnt_q} + 7'd1);
                end else if (accept) begin
                    data_d    = data_in;
                    load_hold = 1'b1;
                    par_d     = par_q ^ data_in;
                    cnt_d     = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = S_PARITY;
                    end
                end
            end

            S_PARITY: begin
                if (srst_dest) begin
                    clear_hold = 1'b1;
                    if (accept) begin
                        state_d = S_IDLE;
                    end else begin
                        drop_cnt_d = 7'd1;
                        state_d    = S_DROP;
                    end
                end else if (accept) begin
                    data_d    = data_in;
                    load_hold = 1'b1;
                    rx_par_d  = data_in;
                    state_d   = S_CHECK;
                end
            end

            S_CHECK: begin
                if (srst_dest) begin
                    // Packet cut short: no completion report, err keeps its value.
                    clear_hold = 1'b1;
                    state_d    = S_IDLE;
                end else if (!hold_vld_q) begin
                    err_d         = (rx_par_q != par_q);
                    parity_done_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end

            S_DROP: begin
                if (accept) begin
                    drop_cnt_d = drop_cnt_q - 7'd1;
                    if (drop_cnt_q == 7'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A newly accepted byte refills hold in the same edge that drains it.
        if (load_hold) begin
            hold_vld_d = 1'b1;
        end else if (clear_hold || wr_go) begin
            hold_vld_d = 1'b0;
        end else begin
            hold_vld_d = hold_vld_q;
        end
    end

    // Per-channel unread-cycle counters and flush pulse generation.
    always_comb begin
        soft_reset_d = 3'b000;
        tcnt_d       = tcnt_q;
        for (int i = 0; i < 3; i++) begin
            if (read_enb[i] || fifo_empty[i]) begin
                tcnt_d[i] = '0;
            end else if (tcnt_q[i] >= TW'(TIMEOUT - 1)) begin
                tcnt_d[i]       = '0;
                soft_reset_d[i] = 1'b1;
            end else begin
                tcnt_d[i] = tcnt_q[i] + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            hold_vld_q    <= 1'b0;
            data_q        <= '0;
            dest_q        <= 2'd0;
            cnt_q         <= 6'd0;
            par_q         <= '0;
            rx_par_q      <= '0;
            drop_cnt_q    <= 7'd0;
            err_q         <= 1'b0;
            parity_done_q <= 1'b0;
            soft_reset_q  <= 3'b000;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            hold_vld_q    <= hold_vld_d;
            data_q        <= data_d;
            dest_q        <= dest_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            rx_par_q      <= rx_par_d;
            drop_cnt_q    <= drop_cnt_d;
            err_q         <= err_d;
            parity_done_q <= parity_done_d;
            soft_reset_q  <= soft_reset_d;
            tcnt_q        <= tcnt_d;
        end
    end

    assign data_out    = data_q;
    assign write_enb_n = ~wr_vec;
    assign vld_out     = ~fifo_empty;
    assign soft_reset  = soft_reset_q;
    assign parity_done = parity_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_router_ctrl.sv
// Bench for router_ctrl: table of whole packets with their expected
// completion/err/write/busy results, plus directed sequences for FIFO-full
// stalls, reset mid-packet and the read timeout.
module tb_router_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [2:0] fifo_full = 3'b000;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] read_enb = 3'b000;
    logic       busy;
    logic [7:0] data_out;
    logic [2:0] write_enb_n;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       parity_done;
    logic       err;

    router_ctrl #(.DATA_WIDTH(8), .TIMEOUT(30)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .pkt_valid   (pkt_valid),
        .data_in     (data_in),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .read_enb    (read_enb),
        .busy        (busy),
        .data_out    (data_out),
        .write_enb_n (write_enb_n),
        .vld_out     (vld_out),
        .soft_reset  (soft_reset),
        .parity_done (parity_done),
        .err         (err)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    int         wr_cnt = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];

    typedef struct {
        logic [15:0][7:0] b;
        int               n;
        logic             exp_err;
        int               exp_done;
        int               exp_wr;
        int               exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int qsum();
        return exp_q0.size() + exp_q1.size() + exp_q2.size();
    endfunction

    task automatic exp_push(input int ch, input logic [7:0] v);
        case (ch)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic mon_write(input int ch);
        logic [7:0] e;
        int         sz;
        sz = (ch == 0) ? exp_q0.size() : (ch == 1) ? exp_q1.size() : exp_q2.size();
        wr_cnt++;
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write ch%0d: got write of %0h, required no write", ch, data_out);
        end else begin
            case (ch)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check($sformatf("wr_data_ch%0d", ch), 32'(data_out), 32'(e));
        end
    endtask

    // Monitor: every FIFO write must match the next expected byte of its channel.
    always @(negedge clock) begin
        if (mon_en && resetn) begin
            check("one_wr_max", 32'($countones(~write_enb_n) <= 1), 1);
            for (int i = 0; i < 3; i++) begin
                if (!write_enb_n[i]) mon_write(i);
            end
        end
        if (parity_done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input int n, input logic [47:0] by, input logic e,
                                input int dn, input int wr, input int bz);
        vec_t v;
        v.b = '0;
        for (int k = 0; k < 6; k++) v.b[k] = by[47-8*k -: 8];
        v.n        = n;
        v.exp_err  = e;
        v.exp_done = dn;
        v.exp_wr   = wr;
        v.exp_busy = bz;
        return v;
    endfunction

    // Stream n bytes; fifo_full[fch] is forced high during cycles [st, st+sl).
    task automatic send_pkt(input logic [15:0][7:0] b, input int n, input bit hdr,
                            input int fch, input int st, input int sl, output int nbusy);
        int idx;
        int c;
        bit hdr_chk;
        bit stall;
        idx = 0;
        c = 0;
        hdr_chk = 1'b0;
        nbusy = 0;
        while (idx < n && c < 200) begin
            stall = (fch >= 0) && (c >= st) && (c < st + sl);
            pkt_valid = 1'b1;
            data_in = b[idx];
            fifo_full = stall ? 3'(1 << fch) : 3'b000;
            @(negedge clock);
            if (hdr_chk) begin
                check("err_clr_on_hdr", 32'(err), 0);
                hdr_chk = 1'b0;
            end
            if (stall) begin
                check("stall_busy", 32'(busy), 1);
                check("stall_no_write", 32'(write_enb_n), 7);
            end
            if (fch >= 0 && c == st + sl) check("stall_release", 32'(busy), 0);
            if (busy) begin
                nbusy++;
            end else begin
                if (idx == 0 && hdr) hdr_chk = 1'b1;
                idx++;
            end
            tick();
            c++;
        end
        pkt_valid = 1'b0;
        fifo_full = 3'b000;
        check("all_accepted", idx, n);
    endtask

    task automatic run_pkt(input vec_t v, input int fch, input int st, input int sl);
        int d0;
        int w0;
        int nb;
        if (v.b[0][1:0] != 2'd3) begin
            for (int k = 0; k < v.n; k++) exp_push(int'(v.b[0][1:0]), v.b[k]);
        end
        d0 = done_cnt;
        w0 = wr_cnt;
        send_pkt(v.b, v.n, 1'b1, fch, st, sl, nb);
        check("busy_cycles", nb, v.exp_busy);
        repeat (6) tick();
        check("parity_done_cnt", done_cnt - d0, v.exp_done);
        check("err", 32'(err), 32'(v.exp_err));
        check("write_cnt", wr_cnt - w0, v.exp_wr);
        check("pending_bytes", qsum(), 0);
    endtask

    // ---------------- stimulus ----------------
    vec_t             tbl[6];
    vec_t             ok0;
    logic [15:0][7:0] bb;
    int               first;
    int               np;
    int               other;
    int               nb;
    int               d0;
    int               w0;

    initial begin
        // n, bytes (first = header), err, parity_done count, writes, busy cycles
        tbl[0] = mk(5, {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00}, 1'b0, 1, 5, 1);
        tbl[1] = mk(5, {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E, 8'h00}, 1'b1, 1, 5, 1);
        tbl[2] = mk(4, {8'h0B, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00}, 1'b0, 0, 0, 0);
        tbl[3] = mk(2, {8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1, 2, 1);
        tbl[4] = mk(3, {8'h04, 8'hAA, 8'hAE, 8'h00, 8'h00, 8'h00}, 1'b0, 1, 3, 1);
        tbl[5] = mk(5, {8'h0E, 8'h01, 8'h02, 8'h03, 8'h0F, 8'h00}, 1'b1, 1, 5, 1);
        ok0    = mk(3, {8'h04, 8'hAA, 8'hAE, 8'h00, 8'h00, 8'h00}, 1'b0, 1, 3, 1);

        // Reset state
        resetn = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_wen", 32'(write_enb_n), 7);
        check("rst_data", 32'(data_out), 0);
        check("rst_err", 32'(err), 0);
        check("rst_pdone", 32'(parity_done), 0);
        check("rst_srst", 32'(soft_reset), 0);
        check("rst_vld", 32'(vld_out), 0);
        resetn = 1'b1;
        tick();

        // Whole packets from the table
        for (int i = 0; i < 6; i++) run_pkt(tbl[i], -1, 0, 0);

        // FIFO1 full for 3 cycles mid-payload
        run_pkt(mk(5, {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00}, 1'b0, 1, 5, 4), 1, 3, 3);

        // Reset while in PAYLOAD with a byte in hold
        mon_en = 1'b0;
        bb = '0;
        bb[0] = 8'h0D;
        bb[1] = 8'h11;
        bb[2] = 8'h22;
        send_pkt(bb, 3, 1'b1, -1, 0, 0, nb);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_wen", 32'(write_enb_n), 7);
        check("midrst_data", 32'(data_out), 0);
        check("midrst_err", 32'(err), 0);
        mon_en = 1'b1;
        run_pkt(ok0, -1, 0, 0);

        // Timeout on ch2 with no reads: one pulse after 30 cycles
        fifo_empty = 3'b011;
        first = -1;
        np = 0;
        other = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (k == 0) check("vld_out", 32'(vld_out), 4);
            if (soft_reset[2]) begin
                np++;
                if (first < 0) first = k;
            end
            if (soft_reset[1:0] != 2'b00) other++;
            tick();
        end
        check("to_first", first, 30);
        check("to_pulses", np, 1);
        check("to_other_ch", other, 0);
        fifo_empty = 3'b111;
        tick();

        // Read at the 29th cycle restarts the count: no pulse in window
        fifo_empty = 3'b011;
        np = 0;
        for (int k = 0; k < 46; k++) begin
            read_enb = (k == 28) ? 3'b100 : 3'b000;
            @(negedge clock);
            if (soft_reset[2]) np++;
            tick();
        end
        read_enb = 3'b000;
        check("to_read_no_pulse", np, 0);
        fifo_empty = 3'b111;
        tick();

        // Timeout during ch2 PAYLOAD (len 15): remainder of packet dropped
        bb = '0;
        bb[0] = 8'h3E;
        bb[1] = 8'h10;
        bb[2] = 8'h20;
        for (int k = 0; k < 3; k++) exp_push(2, bb[k]);
        w0 = wr_cnt;
        d0 = done_cnt;
        send_pkt(bb, 3, 1'b1, -1, 0, 0, nb);
        fifo_empty = 3'b011;
        first = -1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            if (soft_reset[2] && first < 0) first = k;
            tick();
        end
        fifo_empty = 3'b111;
        check("to_pl_first", first, 30);
        check("to_pl_writes", wr_cnt - w0, 3);
        check("to_pl_pending", qsum(), 0);
        w0 = wr_cnt;
        bb = {16{8'h40}};
        send_pkt(bb, 14, 1'b0, -1, 0, 0, nb);
        repeat (4) tick();
        check("drop_busy", nb, 0);
        check("drop_writes", wr_cnt - w0, 0);
        check("drop_no_pdone", done_cnt - d0, 0);
        run_pkt(ok0, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Run-length bound
    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got no end of test, required end within 200000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
